// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle control unit and the memory responder.
interface mem_responder_if;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_misaligned;
   logic        mem_busy;

   modport master (
      output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready, mem_misaligned, mem_busy
   );

   modport slave (
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      output mem_rdata, mem_ready, mem_misaligned, mem_busy
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the IorD address path: one request per transaction, word array,
// WAIT_STATES wait cycles. Define MEM_SIGNEXT_EN to sign-extend byte/halfword reads.
module mem_responder #(
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic             clk,
   input  logic             reset,
   mem_responder_if.slave   bus
);

   localparam int unsigned AW    = ADDR_BITS + 2;
   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
   localparam bit NO_WAIT = (WAIT_STATES == 0);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              wr_q, wr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              misaligned_q, misaligned_d;
   logic              busy_q, busy_d;

   logic [31:0]       mem_q [DEPTH];

   logic              accept, illegal, do_access, mem_we;
   logic [AW-1:0]     cur_addr;
   logic [31:0]       cur_wdata;
   logic [1:0]        cur_size;
   logic              cur_wr;
   logic [31:0]       word, rd_val, lane_mask, lane_data, merged;
   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^bus.mem_addr[31:AW];

   // In IDLE the request comes straight off the bus; afterwards from the latched copy.
   always_comb begin
      accept = (state_q == ST_IDLE) && bus.mem_req;
      if (state_q == ST_IDLE) begin
         cur_addr  = bus.mem_addr[AW-1:0];
         cur_wdata = bus.mem_wdata;
         cur_size  = bus.mem_size;
         cur_wr    = bus.mem_wr;
      end else begin
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_size  = size_q;
         cur_wr    = wr_q;
      end
      illegal = (cur_size == 2'b11) ||
                ((cur_size == 2'b01) && cur_addr[0]) ||
                ((cur_size == 2'b00) && (cur_addr[1:0] != 2'b00));
      do_access = (accept && !illegal && NO_WAIT) ||
                  ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
      mem_we = do_access && cur_wr;
   end

   // Lane extraction and read-modify-write merge for the addressed word.
   always_comb begin
      word     = mem_q[cur_addr[AW-1:2]];
      half_sel = cur_addr[1] ? word[31:16] : word[15:0];
      case (cur_addr[1:0])
         2'b00:   byte_sel = word[7:0];
         2'b01:   byte_sel = word[15:8];
         2'b10:   byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      case (cur_size)
`ifdef MEM_SIGNEXT_EN
         2'b01:   rd_val = {{16{half_sel[15]}}, half_sel};
         2'b10:   rd_val = {{24{byte_sel[7]}}, byte_sel};
`else
         2'b01:   rd_val = {16'h0000, half_sel};
         2'b10:   rd_val = {24'h00_0000, byte_sel};
`endif
         default: rd_val = word;
      endcase
      case (cur_size)
         2'b01: begin
            lane_mask = cur_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            lane_data = {2{cur_wdata[15:0]}};
         end
         2'b10: begin
            lane_mask = 32'h0000_00FF << {cur_addr[1:0], 3'b000};
            lane_data = {4{cur_wdata[7:0]}};
         end
         default: begin
            lane_mask = 32'hFFFF_FFFF;
            lane_data = cur_wdata;
         end
      endcase
      merged = (word & ~lane_mask) | (lane_data & lane_mask);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and wait counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.mem_req) begin
               if (illegal || NO_WAIT) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and request-latch logic.
   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      wr_d         = wr_q;
      rdata_d      = rdata_q;
      ready_d      = do_access;
      misaligned_d = accept && illegal;
      busy_d       = (state_d != ST_IDLE);
      if (accept) begin
         addr_d  = cur_addr;
         wdata_d = cur_wdata;
         size_d  = cur_size;
         wr_d    = cur_wr;
      end
      if (do_access && !cur_wr) rdata_d = rd_val;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         wr_q         <= 1'b0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         misaligned_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         wr_q         <= wr_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         misaligned_q <= misaligned_d;
         busy_q       <= busy_d;
      end
   end

   // Array contents survive reset; an aborted transaction never reaches this write.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[cur_addr[AW-1:2]] <= merged;
   end

   assign bus.mem_rdata      = rdata_q;
   assign bus.mem_ready      = ready_q;
   assign bus.mem_misaligned = misaligned_q;
   assign bus.mem_busy       = busy_q;

endmodule
